// File: rtl/bounded_counter.sv
// Up/down counter with load, programmable step and a [limit_lo, limit_hi] window.
// Boundary handling is selectable: wrap, saturate, or one-shot halt.
module bounded_counter #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  down,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      limit_lo,
    input  logic [WIDTH-1:0]      limit_hi,
    input  logic [1:0]            mode,
    output logic [WIDTH-1:0]      out,
    output logic                  tc,
    output logic                  halted,
    output logic                  cfg_err
);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             halted_q, halted_d;

    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH:0]   out_ext_s;
    logic [WIDTH:0]   up_sum_s;
    logic [WIDTH:0]   lo_plus_step_s;
    logic             count_s;
    logic             boundary_s;

    // One extra bit so that out+step and limit_lo+step never wrap at 2^WIDTH.
    assign step_ext_s     = {{(WIDTH+1-STEP_WIDTH){1'b0}}, step};
    assign out_ext_s      = {1'b0, out_q};
    assign up_sum_s       = out_ext_s + step_ext_s;
    assign lo_plus_step_s = {1'b0, limit_lo} + step_ext_s;

    assign cfg_err = (limit_lo > limit_hi);
    assign count_s = en & ~load & ~halted_q & ~cfg_err & (step != {STEP_WIDTH{1'b0}});

    // Boundary detection for the current direction.
    always_comb begin
        boundary_s = 1'b0;
        if (down) begin
            boundary_s = (out_ext_s < lo_plus_step_s);
        end else begin
            boundary_s = (up_sum_s > {1'b0, limit_hi});
        end
    end

    // Next-state selection: load > count > hold.
    always_comb begin
        out_d    = out_q;
        tc_d     = 1'b0;
        halted_d = halted_q;
        if (load) begin
            out_d    = load_value;
            halted_d = 1'b0;
        end else if (count_s) begin
            if (!boundary_s) begin
                if (down) begin
                    out_d = out_q - step_ext_s[WIDTH-1:0];
                end else begin
                    out_d = up_sum_s[WIDTH-1:0];
                end
            end else begin
                tc_d = 1'b1;
                case (mode)
                    MODE_SAT: begin
                        out_d = down ? limit_lo : limit_hi;
                    end
                    MODE_ONESHOT: begin
                        out_d    = down ? limit_lo : limit_hi;
                        halted_d = 1'b1;
                    end
                    MODE_WRAP: begin
                        out_d = down ? limit_hi : limit_lo;
                    end
                    default: begin
                        out_d = down ? limit_hi : limit_lo;
                    end
                endcase
            end
        end else begin
            out_d = out_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= {WIDTH{1'b0}};
            tc_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            tc_q     <= tc_d;
            halted_q <= halted_d;
        end
    end

    assign out    = out_q;
    assign tc     = tc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_bounded_counter.sv
// Directed-vector bench for bounded_counter with hand-computed expectations.
module tb_bounded_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] load_value;
    logic       down;
    logic [3:0] step;
    logic [7:0] limit_lo;
    logic [7:0] limit_hi;
    logic [1:0] mode;
    logic [7:0] out;
    logic       tc;
    logic       halted;
    logic       cfg_err;

    int n_vec = 0;
    int n_err = 0;

    bounded_counter #(.WIDTH(8), .STEP_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_value(load_value),
        .down(down), .step(step), .limit_lo(limit_lo), .limit_hi(limit_hi),
        .mode(mode), .out(out), .tc(tc), .halted(halted), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [7:0] e_out,
                            input logic e_tc, input logic e_halt);
        tick();
        chk({tag, ".out"}, 32'(out), 32'(e_out));
        chk({tag, ".tc"}, 32'(tc), 32'(e_tc));
        chk({tag, ".halted"}, 32'(halted), 32'(e_halt));
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_value = v;
        tick();
        load = 1'b0;
    endtask

    logic [7:0] seq2 [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h10};
    logic       tc2  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; load_value = 8'h00; down = 1'b0;
        step = 4'd1; limit_lo = 8'h00; limit_hi = 8'hFF; mode = 2'b00;
        #3;
        chk("rst.out", 32'(out), 32'h0);
        chk("rst.tc", 32'(tc), 32'h0);
        chk("rst.halted", 32'(halted), 32'h0);
        chk("rst.cfg_err", 32'(cfg_err), 32'h0);
        #4 reset = 1'b0;

        // wrap up through the window
        limit_lo = 8'h10; limit_hi = 8'h14; step = 4'd1; mode = 2'b00; down = 1'b0;
        do_load(8'h10);
        chk("t2.load", 32'(out), 32'h10);
        en = 1'b1;
        for (int i = 0; i < 5; i++) step_chk($sformatf("t2.%0d", i), seq2[i], tc2[i], 1'b0);
        en = 1'b0;
        step_chk("t2.hold", 8'h10, 1'b0, 1'b0);

        // wrap down (mode 11 aliases wrap) and out-of-window load
        mode = 2'b11; down = 1'b1;
        do_load(8'h11);
        en = 1'b1;
        step_chk("tw.d0", 8'h10, 1'b0, 1'b0);
        step_chk("tw.d1", 8'h14, 1'b1, 1'b0);
        en = 1'b0; down = 1'b0;
        do_load(8'h50);
        en = 1'b1;
        step_chk("tw.oow", 8'h10, 1'b1, 1'b0);
        en = 1'b0;

        // saturate down
        limit_lo = 8'h05; limit_hi = 8'hF0; step = 4'd3; mode = 2'b01; down = 1'b1;
        do_load(8'h0A);
        en = 1'b1;
        step_chk("t3.0", 8'h07, 1'b0, 1'b0);
        step_chk("t3.1", 8'h05, 1'b1, 1'b0);
        step_chk("t3.2", 8'h05, 1'b1, 1'b0);
        step_chk("t3.3", 8'h05, 1'b1, 1'b0);
        en = 1'b0;

        // one-shot up
        limit_lo = 8'h00; limit_hi = 8'h06; step = 4'd2; mode = 2'b10; down = 1'b0;
        do_load(8'h00);
        en = 1'b1;
        step_chk("t4.0", 8'h02, 1'b0, 1'b0);
        step_chk("t4.1", 8'h04, 1'b0, 1'b0);
        step_chk("t4.2", 8'h06, 1'b0, 1'b0);
        step_chk("t4.3", 8'h06, 1'b1, 1'b1);
        step_chk("t4.4", 8'h06, 1'b0, 1'b1);
        step_chk("t4.5", 8'h06, 1'b0, 1'b1);
        load = 1'b1; load_value = 8'h01;
        step_chk("t4.ld", 8'h01, 1'b0, 1'b0);
        load = 1'b0;
        step_chk("t4.res", 8'h03, 1'b0, 1'b0);

        // load beats count; zero step holds
        mode = 2'b00; limit_hi = 8'hFF; step = 4'd1;
        load = 1'b1; load_value = 8'hAA;
        step_chk("t5.ld", 8'hAA, 1'b0, 1'b0);
        load = 1'b0; step = 4'd0;
        step_chk("t5.z0", 8'hAA, 1'b0, 1'b0);
        step_chk("t5.z1", 8'hAA, 1'b0, 1'b0);

        // bad config freezes counting but not load
        limit_lo = 8'h20; limit_hi = 8'h10; step = 4'd1;
        #1;
        chk("t6.cfg_err", 32'(cfg_err), 32'h1);
        step_chk("t6.hold", 8'hAA, 1'b0, 1'b0);
        load = 1'b1; load_value = 8'h55;
        step_chk("t6.ld", 8'h55, 1'b0, 1'b0);
        load = 1'b0;
        step_chk("t6.hold2", 8'h55, 1'b0, 1'b0);

        // async reset mid-count while halted at 0x37
        limit_lo = 8'h00; limit_hi = 8'h37; mode = 2'b10; down = 1'b0; step = 4'd1;
        #1;
        chk("t1.cfg_ok", 32'(cfg_err), 32'h0);
        do_load(8'h36);
        step_chk("t1.0", 8'h37, 1'b0, 1'b0);
        step_chk("t1.1", 8'h37, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t1.async.out", 32'(out), 32'h0);
        chk("t1.async.tc", 32'(tc), 32'h0);
        chk("t1.async.halted", 32'(halted), 32'h0);
        #2 reset = 1'b0;
        en = 1'b0;
        step_chk("t1.post", 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
